// File: rtl/i2c_xfer_sequencer.sv
// Register-level I2C transaction sequencer: turns one (dev, reg, rw, len) request
// into START / address / register / [repeated START] / data / STOP byte commands.
module i2c_xfer_sequencer #(
  parameter int MAX_LEN     = 16,
  parameter int LEN_W       = 5,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_dev_addr,
  input  logic [7:0]       req_reg_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [7:0]       cmd_wdata,
  output logic             cmd_nack,
  input  logic             core_done,
  input  logic             core_rx_nack,
  input  logic [7:0]       core_rdata,
  output logic             core_abort,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status
);

  localparam int               TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_DEV_W  = 4'd2;
  localparam logic [3:0] S_REG    = 4'd3;
  localparam logic [3:0] S_WGET   = 4'd4;
  localparam logic [3:0] S_WDATA  = 4'd5;
  localparam logic [3:0] S_RSTART = 4'd6;
  localparam logic [3:0] S_DEV_R  = 4'd7;
  localparam logic [3:0] S_RDATA  = 4'd8;
  localparam logic [3:0] S_RHOLD  = 4'd9;
  localparam logic [3:0] S_STOP   = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_ADDR_NACK = 3'd1;
  localparam logic [2:0] ST_REG_NACK  = 3'd2;
  localparam logic [2:0] ST_DATA_NACK = 3'd3;
  localparam logic [2:0] ST_TIMEOUT   = 3'd4;
  localparam logic [2:0] ST_BAD_LEN   = 3'd5;

  logic [3:0]       state;
  logic             waiting;
  logic [TMR_W-1:0] timer;
  logic             rw_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] cnt;
  logic [7:0]       wbyte;
  logic             cmd_state;
  logic             last_byte;
  logic             bad_len;
  logic             timeout_hit;

  always_comb begin
    case (state)
      S_START, S_DEV_W, S_REG, S_WDATA,
      S_RSTART, S_DEV_R, S_RDATA, S_STOP: cmd_state = 1'b1;
      default:                            cmd_state = 1'b0;
    endcase
  end

  assign last_byte   = (cnt == LEN_ONE);
  assign bad_len     = (req_len == '0) || (req_len > LEN_MAX);
  // Abort fires in the last allowed WAIT cycle, so the core sees it together with the move to DONE.
  assign timeout_hit = TMO_EN && cmd_state && waiting && !core_done && (timer == TMR_LAST);

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign cmd_valid  = cmd_state && !waiting;
  assign core_abort = timeout_hit;
  assign wr_ready   = (state == S_WGET) && wr_valid;

  always_comb begin
    cmd_op    = OP_START;
    cmd_wdata = 8'h00;
    cmd_nack  = 1'b0;
    case (state)
      S_STOP:  cmd_op = OP_STOP;
      S_DEV_W: begin cmd_op = OP_WRITE; cmd_wdata = {dev_q, 1'b0}; end
      S_DEV_R: begin cmd_op = OP_WRITE; cmd_wdata = {dev_q, 1'b1}; end
      S_REG:   begin cmd_op = OP_WRITE; cmd_wdata = reg_q; end
      S_WDATA: begin cmd_op = OP_WRITE; cmd_wdata = wbyte; end
      S_RDATA: begin cmd_op = OP_READ;  cmd_nack  = last_byte; end
      default: cmd_op = OP_START;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= S_IDLE;
      waiting  <= 1'b0;
      timer    <= '0;
      rw_q     <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      cnt      <= '0;
      wbyte    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      status   <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rw_q    <= req_rw;
            dev_q   <= req_dev_addr;
            reg_q   <= req_reg_addr;
            cnt     <= req_len;
            waiting <= 1'b0;
            if (bad_len) begin
              status <= ST_BAD_LEN;
              state  <= S_DONE;
            end else begin
              status <= ST_OK;
              state  <= S_START;
            end
          end
        end
        S_WGET: begin
          if (wr_valid) begin
            wbyte <= wr_data;
            state <= S_WDATA;
          end
        end
        S_RHOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (cnt != '0) cnt <= cnt - LEN_ONE;
            state <= last_byte ? S_STOP : S_RDATA;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (!cmd_state) begin
            state <= S_IDLE;
          end else if (!waiting) begin
            if (cmd_ready) begin
              waiting <= 1'b1;
              timer   <= '0;
            end
          end else if (core_done) begin
            waiting <= 1'b0;
            // Any NACK on a byte we wrote skips the rest of the transfer but still releases the bus.
            case (state)
              S_START: state <= S_DEV_W;
              S_DEV_W: begin
                if (core_rx_nack) begin status <= ST_ADDR_NACK; state <= S_STOP; end
                else state <= S_REG;
              end
              S_REG: begin
                if (core_rx_nack) begin status <= ST_REG_NACK; state <= S_STOP; end
                else state <= rw_q ? S_RSTART : S_WGET;
              end
              S_WDATA: begin
                if (core_rx_nack) begin
                  status <= ST_DATA_NACK;
                  state  <= S_STOP;
                end else begin
                  if (cnt != '0) cnt <= cnt - LEN_ONE;
                  state <= last_byte ? S_STOP : S_WGET;
                end
              end
              S_RSTART: state <= S_DEV_R;
              S_DEV_R: begin
                if (core_rx_nack) begin status <= ST_ADDR_NACK; state <= S_STOP; end
                else state <= S_RDATA;
              end
              S_RDATA: begin
                rd_data  <= core_rdata;
                rd_valid <= 1'b1;
                state    <= S_RHOLD;
              end
              S_STOP:  state <= S_DONE;
              default: state <= S_IDLE;
            endcase
          end else if (timeout_hit) begin
            waiting <= 1'b0;
            status  <= ST_TIMEOUT;
            state   <= S_DONE;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Bench for i2c_xfer_sequencer: behavioural byte-level core, payload source and
// read sink, with expected command and read-byte scoreboards.
module tb_i2c_xfer_sequencer;

  localparam int LEN_W = 5;
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;
  localparam logic [28:0] RESET_VEC = {1'b1, 28'h0};

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_rw = 1'b0;
  logic [6:0]       req_dev_addr = '0;
  logic [7:0]       req_reg_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic             cmd_valid;
  logic             cmd_ready = 1'b1;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_wdata;
  logic             cmd_nack;
  logic             core_done = 1'b0;
  logic             core_rx_nack = 1'b0;
  logic [7:0]       core_rdata = '0;
  logic             core_abort;
  logic             busy;
  logic             done;
  logic [2:0]       status;

  i2c_xfer_sequencer #(.MAX_LEN(16), .LEN_W(LEN_W), .TIMEOUT_CYC(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack),
    .core_done(core_done), .core_rx_nack(core_rx_nack), .core_rdata(core_rdata),
    .core_abort(core_abort), .busy(busy), .done(done), .status(status)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int resp_cnt = 0;
  logic resp_nack = 1'b0;
  logic [7:0] resp_data = '0;
  int txn_idx = 0;
  int nack_idx = -1;
  bit hang = 1'b0;
  int wr_pulses = 0;
  bit wr_pend = 1'b0;
  int rd_idx = 0;
  int rd_hold = 0;
  int rd_slow_idx = -1;
  int n_hs = 0;
  int n_cmdv = 0;
  int n_abort = 0;
  int hs_cyc = 0;
  int abort_cyc = 0;
  logic [10:0] mon_obs, mon_exp;
  logic [7:0]  rd_exp;
  logic [7:0]  wrq[$];
  logic [7:0]  rdq[$];
  logic [7:0]  exp_rd_q[$];
  logic [10:0] exp_cmd_q[$];

  // Only the fields that matter for each opcode take part in the comparison.
  function automatic logic [10:0] cmd_key(input logic [1:0] op, input logic [7:0] wd, input logic nk);
    case (op)
      OP_WRITE: return {op, wd, 1'b0};
      OP_READ:  return {op, 8'h00, nk};
      default:  return {op, 9'h000};
    endcase
  endfunction

  always @(negedge ACLK) begin
    cyc++;
    core_done    = 1'b0;
    core_rx_nack = 1'b0;
    if (!ARESETN) begin
      resp_cnt = 0;
      rd_ready = 1'b0;
      rd_hold  = 0;
      wr_pend  = 1'b0;
    end else begin
      if (wr_pend) begin
        if (wrq.size() != 0) wrq.delete(0);
        wr_pend = 1'b0;
      end else if (wr_valid && wr_ready) begin
        wr_pulses++;
        wr_pend = 1'b1;
      end
      if (wrq.size() != 0) begin wr_valid = 1'b1; wr_data = wrq[0]; end
      else begin wr_valid = 1'b0; wr_data = 8'h00; end

      if (rd_ready) begin
        rd_ready = 1'b0;
        rd_hold  = 0;
      end else if (rd_valid) begin
        if (rd_hold >= ((rd_idx == rd_slow_idx) ? 4 : 0)) begin
          rd_ready = 1'b1;
          n_tests++;
          if (exp_rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_extra: got rd_data=%02h, expected no read byte", rd_data);
          end else begin
            rd_exp = exp_rd_q.pop_front();
            if (rd_data !== rd_exp) begin
              n_fail++;
              $display("FAIL rd_data[%0d]: got %02h, expected %02h", rd_idx, rd_data, rd_exp);
            end
          end
          rd_idx++;
        end else begin
          rd_hold++;
        end
      end

      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          core_done    = 1'b1;
          core_rx_nack = resp_nack;
          core_rdata   = resp_data;
        end
      end
      if (cmd_valid) n_cmdv++;
      if (cmd_valid && cmd_ready) begin
        mon_obs = cmd_key(cmd_op, cmd_wdata, cmd_nack);
        n_tests++;
        if (exp_cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_extra: got op=%0d wdata=%02h nack=%0b, expected no command",
                   cmd_op, cmd_wdata, cmd_nack);
        end else begin
          mon_exp = exp_cmd_q.pop_front();
          if (mon_obs !== mon_exp) begin
            n_fail++;
            $display("FAIL cmd_seq[%0d]: got op=%0d wdata=%02h nack=%0b, expected op=%0d wdata=%02h nack=%0b",
                     txn_idx, mon_obs[10:9], mon_obs[8:1], mon_obs[0], mon_exp[10:9], mon_exp[8:1], mon_exp[0]);
          end
        end
        resp_nack = (txn_idx == nack_idx);
        resp_data = (cmd_op == OP_READ && rdq.size() != 0) ? rdq.pop_front() : 8'h00;
        if (!hang) resp_cnt = 3;
        hs_cyc = cyc;
        txn_idx++;
        n_hs++;
      end
      if (core_abort) begin
        n_abort++;
        abort_cyc = cyc;
      end
    end
  end

  task automatic begin_txn();
    txn_idx = 0; nack_idx = -1; hang = 1'b0; wr_pulses = 0; rd_idx = 0; rd_slow_idx = -1;
    n_hs = 0; n_cmdv = 0; n_abort = 0;
    exp_cmd_q.delete(); exp_rd_q.delete(); rdq.delete(); wrq.delete();
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] wd, input logic nk);
    exp_cmd_q.push_back(cmd_key(op, wd, nk));
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [LEN_W-1:0] len, input int hold_extra);
    @(negedge ACLK);
    req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_len = len; req_valid = 1'b1;
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) @(negedge ACLK);
    @(negedge ACLK);
    n_tests++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL req_accept: got req_ready=%0b busy=%0b, expected req_ready=0 busy=1", req_ready, busy);
    end
    req_dev_addr = 7'h7F;
    for (int i = 0; i < hold_extra; i++) begin
      @(negedge ACLK);
      n_tests++;
      if (req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL req_while_busy: got req_ready=%0b, expected 0", req_ready);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic [2:0] st, output int waited);
    waited = -1;
    st = 3'h7;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) begin
        waited = i;
        st = status;
        break;
      end
      @(negedge ACLK);
    end
    if (waited < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", limit);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    n_tests++;
    if ({req_ready, wr_ready, rd_valid, rd_data, cmd_valid, cmd_op, cmd_wdata, cmd_nack,
         core_abort, busy, done, status} !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_outputs: got req_ready=%0b busy=%0b cmd_valid=%0b status=%0d, expected req_ready=1 all else 0",
               req_ready, busy, cmd_valid, status);
    end
    ARESETN = 1'b1;
    @(negedge ACLK);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got req_ready=%0b busy=%0b, expected 1/0", req_ready, busy);
    end
  endtask

  task automatic test_write();
    logic [2:0] st;
    int w;
    begin_txn();
    wrq.push_back(8'hA5); wrq.push_back(8'h3C);
    push_cmd(OP_START, 8'h00, 1'b0); push_cmd(OP_WRITE, 8'hA0, 1'b0); push_cmd(OP_WRITE, 8'h10, 1'b0);
    push_cmd(OP_WRITE, 8'hA5, 1'b0); push_cmd(OP_WRITE, 8'h3C, 1'b0); push_cmd(OP_STOP, 8'h00, 1'b0);
    send_req(1'b0, 7'h50, 8'h10, 5'd2, 3);
    wait_done(500, st, w);
    n_tests++;
    if (st !== 3'd0) begin n_fail++; $display("FAIL write_status: got %0d, expected 0", st); end
    n_tests++;
    if (wr_pulses != 2) begin n_fail++; $display("FAIL write_wr_ready: got %0d pulses, expected 2", wr_pulses); end
    n_tests++;
    if (n_hs != 6 || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL write_cmd_count: got %0d commands (%0d still expected), expected 6", n_hs, exp_cmd_q.size());
    end
  endtask

  task automatic test_read();
    logic [2:0] st;
    int w;
    begin_txn();
    rdq.push_back(8'h11); rdq.push_back(8'h22); rdq.push_back(8'h33);
    exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h22); exp_rd_q.push_back(8'h33);
    rd_slow_idx = 1;
    push_cmd(OP_START, 8'h00, 1'b0); push_cmd(OP_WRITE, 8'hA0, 1'b0); push_cmd(OP_WRITE, 8'h20, 1'b0);
    push_cmd(OP_START, 8'h00, 1'b0); push_cmd(OP_WRITE, 8'hA1, 1'b0);
    push_cmd(OP_READ, 8'h00, 1'b0); push_cmd(OP_READ, 8'h00, 1'b0); push_cmd(OP_READ, 8'h00, 1'b1);
    push_cmd(OP_STOP, 8'h00, 1'b0);
    send_req(1'b1, 7'h50, 8'h20, 5'd3, 0);
    wait_done(500, st, w);
    n_tests++;
    if (st !== 3'd0) begin n_fail++; $display("FAIL read_status: got %0d, expected 0", st); end
    n_tests++;
    if (rd_idx != 3 || exp_rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_bytes: got %0d bytes delivered, expected 3", rd_idx);
    end
    n_tests++;
    if (n_hs != 9 || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_cmd_count: got %0d commands (%0d still expected), expected 9", n_hs, exp_cmd_q.size());
    end
  endtask

  task automatic test_addr_nack();
    logic [2:0] st;
    int w;
    begin_txn();
    nack_idx = 1;
    wrq.push_back(8'h5A); wrq.push_back(8'hC3);
    push_cmd(OP_START, 8'h00, 1'b0); push_cmd(OP_WRITE, 8'hA0, 1'b0); push_cmd(OP_STOP, 8'h00, 1'b0);
    send_req(1'b0, 7'h50, 8'h10, 5'd2, 0);
    wait_done(500, st, w);
    n_tests++;
    if (st !== 3'd1) begin n_fail++; $display("FAIL addr_nack_status: got %0d, expected 1", st); end
    n_tests++;
    if (wr_pulses != 0 || n_hs != 3 || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL addr_nack_flow: got %0d wr_ready pulses and %0d commands, expected 0 and 3", wr_pulses, n_hs);
    end
    repeat (3) @(negedge ACLK);
    n_tests++;
    if (status !== 3'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL status_hold: got status=%0d busy=%0b, expected 1/0", status, busy);
    end
    wrq.delete();
  endtask

  task automatic test_data_nack();
    logic [2:0] st;
    int w;
    begin_txn();
    nack_idx = 4;
    wrq.push_back(8'h01); wrq.push_back(8'h02); wrq.push_back(8'h03); wrq.push_back(8'h04);
    push_cmd(OP_START, 8'h00, 1'b0); push_cmd(OP_WRITE, 8'hA0, 1'b0); push_cmd(OP_WRITE, 8'h44, 1'b0);
    push_cmd(OP_WRITE, 8'h01, 1'b0); push_cmd(OP_WRITE, 8'h02, 1'b0); push_cmd(OP_STOP, 8'h00, 1'b0);
    send_req(1'b0, 7'h50, 8'h44, 5'd4, 0);
    wait_done(500, st, w);
    n_tests++;
    if (st !== 3'd3) begin n_fail++; $display("FAIL data_nack_status: got %0d, expected 3", st); end
    n_tests++;
    if (wr_pulses != 2 || n_hs != 6 || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL data_nack_flow: got %0d wr_ready pulses and %0d commands, expected 2 and 6", wr_pulses, n_hs);
    end
    wrq.delete();
  endtask

  task automatic test_bad_len();
    logic [2:0] st;
    int w;
    logic [LEN_W-1:0] lens [2];
    lens[0] = 5'd0;
    lens[1] = 5'd17;
    for (int k = 0; k < 2; k++) begin
      begin_txn();
      send_req(1'b0, 7'h50, 8'h10, lens[k], 0);
      wait_done(10, st, w);
      n_tests++;
      if (st !== 3'd5 || w < 0 || w > 2) begin
        n_fail++;
        $display("FAIL bad_len_%0d: got status=%0d after %0d cycles, expected status 5 within 2", lens[k], st, w);
      end
      n_tests++;
      if (n_cmdv != 0 || n_hs != 0) begin
        n_fail++;
        $display("FAIL bad_len_%0d_cmd: got %0d cmd_valid cycles, expected 0", lens[k], n_cmdv);
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] st;
    int w;
    begin_txn();
    hang = 1'b1;
    push_cmd(OP_START, 8'h00, 1'b0);
    send_req(1'b0, 7'h50, 8'h10, 5'd1, 0);
    wait_done(200, st, w);
    n_tests++;
    if (st !== 3'd4) begin n_fail++; $display("FAIL timeout_status: got %0d, expected 4", st); end
    n_tests++;
    if (n_abort != 1 || (abort_cyc - hs_cyc) != 32) begin
      n_fail++;
      $display("FAIL timeout_abort: got %0d pulses at WAIT cycle %0d, expected 1 pulse at cycle 32",
               n_abort, abort_cyc - hs_cyc);
    end
    n_tests++;
    if (n_hs != 1 || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_no_stop: got %0d commands, expected 1 (START only)", n_hs);
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int found;
    int n_done;
    begin_txn();
    rdq.push_back(8'h11); rdq.push_back(8'h22); rdq.push_back(8'h33);
    exp_rd_q.push_back(8'h11);
    rd_slow_idx = 0;
    push_cmd(OP_START, 8'h00, 1'b0); push_cmd(OP_WRITE, 8'hA0, 1'b0); push_cmd(OP_WRITE, 8'h20, 1'b0);
    push_cmd(OP_START, 8'h00, 1'b0); push_cmd(OP_WRITE, 8'hA1, 1'b0); push_cmd(OP_READ, 8'h00, 1'b0);
    send_req(1'b1, 7'h50, 8'h20, 5'd3, 0);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (rd_valid === 1'b1) begin found = 1; break; end
      @(negedge ACLK);
    end
    n_tests++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL mid_read_reach: got no rd_valid, expected first read byte");
    end
    ARESETN = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, wr_ready, rd_valid, rd_data, cmd_valid, cmd_op, cmd_wdata, cmd_nack,
         core_abort, busy, done, status} !== RESET_VEC) begin
      n_fail++;
      $display("FAIL mid_read_reset: got req_ready=%0b busy=%0b rd_valid=%0b rd_data=%02h, expected 1/0/0/00",
               req_ready, busy, rd_valid, rd_data);
    end
    exp_rd_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read_release: got req_ready=%0b busy=%0b, expected 1/0", req_ready, busy);
    end
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) n_done++;
      @(negedge ACLK);
    end
    n_tests++;
    if (n_done != 0 || n_hs != 6 || exp_cmd_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_read_quiet: got %0d done pulses and %0d commands, expected 0 and 6", n_done, n_hs);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_bad_len();
    test_timeout();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
